// File: rtl/wb_mailbox_if.sv
// rtl/wb_mailbox_if.sv - Wishbone B3 classic 32-bit bus bundle for the mailbox slave
interface wb_mailbox_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/wb_mailbox.sv
// rtl/wb_mailbox.sv - per-core FIFO mailboxes with level irqs behind a Wishbone slave
module wb_mailbox #(
  parameter int NUM_CORES = 2,
  parameter int FIFO_AW   = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  wb_mailbox_if.slave          wb,
  output logic [NUM_CORES-1:0] irq_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_IRQ_EN, REG_CLEAR} reg_e;

  logic [31:0]        mem_q    [NUM_CORES][DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q [NUM_CORES];
  logic [FIFO_AW-1:0] wr_ptr_d [NUM_CORES];
  logic [FIFO_AW-1:0] rd_ptr_q [NUM_CORES];
  logic [FIFO_AW-1:0] rd_ptr_d [NUM_CORES];
  logic [FIFO_AW:0]   cnt_q    [NUM_CORES];
  logic [FIFO_AW:0]   cnt_d    [NUM_CORES];

  logic [NUM_CORES-1:0] irq_en_q, irq_en_d;
  logic [NUM_CORES-1:0] irq_q, irq_d;
  logic [NUM_CORES-1:0] push;
  logic [31:0]          dat_q, dat_d;
  logic                 ack_q, ack_d, err_q, err_d;

  logic       accept;
  logic       legal;
  logic [2:0] mb;
  reg_e       rsel;
  logic       unused_bits;

  // A terminating cycle blocks acceptance, so a held strobe cannot re-trigger side effects.
  assign accept = wb.cyc & wb.stb & ~ack_q & ~err_q;
  assign mb     = wb.adr[6:4];
  assign rsel   = reg_e'(wb.adr[3:2]);
  assign legal  = int'(mb) < NUM_CORES;

  assign unused_bits = ^{wb.sel, wb.cti, wb.bte, wb.adr[31:7], wb.adr[1:0]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    irq_en_d = irq_en_q;
    push     = '0;
    dat_d    = '0;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    if (accept) begin
      ack_d = legal;
      err_d = ~legal;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (legal && mb == 3'(i)) begin
          unique case (rsel)
            REG_DATA: begin
              if (wb.we) begin
                if (cnt_q[i] != FULL_CNT) begin
                  push[i]     = 1'b1;
                  wr_ptr_d[i] = wr_ptr_q[i] + PTR_ONE;
                  cnt_d[i]    = cnt_q[i] + CNT_ONE;
                end else begin
                  ack_d = 1'b0;
                  err_d = 1'b1;
                end
              end else if (cnt_q[i] != '0) begin
                dat_d       = mem_q[i][rd_ptr_q[i]];
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_ONE;
                cnt_d[i]    = cnt_q[i] - CNT_ONE;
              end else begin
                ack_d = 1'b0;
                err_d = 1'b1;
              end
            end
            REG_STATUS: begin
              if (!wb.we) begin
                dat_d[0]               = (cnt_q[i] == '0);
                dat_d[1]               = (cnt_q[i] == FULL_CNT);
                dat_d[8 +: FIFO_AW+1]  = cnt_q[i];
              end
            end
            REG_IRQ_EN: begin
              if (wb.we) irq_en_d[i] = wb.dat_w[0];
              else       dat_d[0]    = irq_en_q[i];
            end
            REG_CLEAR: begin
              if (wb.we) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                cnt_d[i]    = '0;
              end
            end
          endcase
        end
      end
    end
    // Evaluated from next state so irq moves together with the terminating ack.
    for (int i = 0; i < NUM_CORES; i++) begin
      irq_d[i] = irq_en_d[i] & (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      irq_en_q <= '0;
      irq_q    <= '0;
      dat_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      dat_q    <= dat_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  // Storage is never reset or scrubbed; only pointers define validity.
  always_ff @(posedge wb_clk_i) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= wb.dat_w;
    end
  end

  assign wb.dat_r = dat_q;
  assign wb.ack   = ack_q;
  assign wb.err   = err_q;
  assign wb.rty   = 1'b0;
  assign irq_o    = irq_q;

endmodule
